// File: rtl/scan_sequencer.sv
// Channel scan sequencer for a downstream 4-to-16 decoder: walks the enabled
// channels in ascending order with a programmable dwell and a fixed blanking gap.
module scan_sequencer #(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned BLANK   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [15:0]        mask,
  output logic [3:0]         sel,
  output logic               dec_enable,
  output logic               busy,
  output logic               chan_strobe,
  output logic               frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DWELL = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;

  localparam int unsigned BW    = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam int unsigned BLAST = (BLANK > 0) ? BLANK - 1 : 0;

  logic [1:0]         state, state_d;
  logic [3:0]         sel_d, nxt, nxt_d;
  logic [15:0]        mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, cnt, cnt_d;
  logic [BW-1:0]      bcnt, bcnt_d;
  logic               en_d, strobe_d, done_d;
  logic [4:0]         lo, hi;
  logic               last_dwell;

  // Lowest set bit of m at or above index 'from'; bit 4 flags that one exists.
  function automatic logic [4:0] first_from(input logic [15:0] m, input logic [4:0] from);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i] && (5'(i) >= from)) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  assign lo         = first_from(mask, 5'd0);
  assign hi         = first_from(mask_q, 5'(sel) + 5'd1);
  assign last_dwell = (dwell_q == '0) || (cnt == dwell_q - DWELL_W'(1));

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    sel_d    = sel;
    nxt_d    = nxt;
    mask_d   = mask_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt;
    bcnt_d   = bcnt;
    en_d     = 1'b0;
    strobe_d = 1'b0;
    done_d   = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      sel_d   = 4'd0;
      cnt_d   = '0;
      bcnt_d  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_d  = mask;
            dwell_d = dwell;
            cnt_d   = '0;
            if (!lo[4]) begin
              done_d = 1'b1;
            end else begin
              sel_d    = lo[3:0];
              state_d  = S_DWELL;
              en_d     = 1'b1;
              strobe_d = 1'b1;
            end
          end
        end
        S_DWELL: begin
          if (!last_dwell) begin
            cnt_d = cnt + DWELL_W'(1);
            en_d  = 1'b1;
          end else begin
            cnt_d  = '0;
            bcnt_d = '0;
            if (hi[4]) begin
              if (BLANK > 0) begin
                state_d = S_BLANK;
                nxt_d   = hi[3:0];
              end else begin
                sel_d    = hi[3:0];
                en_d     = 1'b1;
                strobe_d = 1'b1;
              end
            end else begin
              done_d = 1'b1;
              if (continuous) begin
                // Frame wrap: recapture so mid-frame edits land here
                mask_d  = mask;
                dwell_d = dwell;
                if (!lo[4]) begin
                  state_d = S_IDLE;
                  sel_d   = 4'd0;
                end else if (BLANK > 0) begin
                  state_d = S_BLANK;
                  nxt_d   = lo[3:0];
                end else begin
                  sel_d    = lo[3:0];
                  en_d     = 1'b1;
                  strobe_d = 1'b1;
                end
              end else begin
                state_d = S_IDLE;
                sel_d   = 4'd0;
              end
            end
          end
        end
        S_BLANK: begin
          if (bcnt == BW'(BLAST)) begin
            bcnt_d   = '0;
            sel_d    = nxt;
            state_d  = S_DWELL;
            en_d     = 1'b1;
            strobe_d = 1'b1;
          end else begin
            bcnt_d = bcnt + BW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          sel_d   = 4'd0;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sel         <= 4'd0;
      nxt         <= 4'd0;
      mask_q      <= '0;
      dwell_q     <= '0;
      cnt         <= '0;
      bcnt        <= '0;
      dec_enable  <= 1'b0;
      busy        <= 1'b0;
      chan_strobe <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_d;
      sel         <= sel_d;
      nxt         <= nxt_d;
      mask_q      <= mask_d;
      dwell_q     <= dwell_d;
      cnt         <= cnt_d;
      bcnt        <= bcnt_d;
      dec_enable  <= en_d;
      busy        <= (state_d != S_IDLE);
      chan_strobe <= strobe_d;
      frame_done  <= done_d;
    end
  end

endmodule
